// File: rtl/btb_update_ctrl.sv
// BTB update controller: takes one resolved branch at a time and issues a verify, allocate or
// round-robin evict op to the entry array. It also handles full-array clears and keeps statistics.
module btb_update_ctrl #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               br_valid,
    output logic               br_ready,
    input  logic [15:0]        br_pc,
    input  logic               br_taken,
    input  logic [15:0]        br_target,
    input  logic               clear_req,
    output logic [2:0]         ent_op,
    output logic [ENTRIES-1:0] ent_en,
    output logic [11:0]        ent_in_pc,
    output logic [15:0]        ent_in_target,
    input  logic [ENTRIES-1:0] ent_update_hit,
    input  logic [ENTRIES-1:0] ent_empty,
    input  logic [ENTRIES-1:0] ent_insert_bubble,
    output logic               mispredict,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);

    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StLookup = 2'd1;
    localparam logic [1:0] StIssue  = 2'd2;
    localparam logic [1:0] StClear  = 2'd3;

    localparam logic [2:0] OpIdle  = 3'b000;
    localparam logic [2:0] OpClear = 3'b111;

    logic [1:0]         state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [ENTRIES-1:0] en_q, en_d;
    logic               mis_q, mis_d;
    logic [IDX_W-1:0]   victim_q, victim_d;
    logic               clr_pend_q, clr_pend_d;
    logic [10:0]        pc_q;
    logic               taken_q;
    logic [15:0]        target_q;
    logic [CNT_W-1:0]   hit_q, miss_q;
    logic               capture, hit_inc, miss_inc;

    logic               hit_any, empty_any;
    logic [IDX_W-1:0]   hit_idx, empty_idx, sel_idx;

    // Only the upper PC bits form the entry tag.
    logic               unused_pc_low;
    assign unused_pc_low = ^br_pc[4:0];

    // Priority encoders: scanning downward leaves the lowest set index.
    always_comb begin
        hit_any   = 1'b0;
        hit_idx   = '0;
        empty_any = 1'b0;
        empty_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (ent_update_hit[i]) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (ent_empty[i]) begin
                empty_any = 1'b1;
                empty_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        if (hit_any) begin
            sel_idx = hit_idx;
        end else if (empty_any) begin
            sel_idx = empty_idx;
        end else begin
            sel_idx = victim_q;
        end
    end

    // A same-cycle clear_req already blocks the handshake.
    assign br_ready = rst_n & (state_q == StIdle) & ~clr_pend_q & ~clear_req;

    always_comb begin
        state_d    = state_q;
        op_d       = OpIdle;
        en_d       = '0;
        mis_d      = 1'b0;
        victim_d   = victim_q;
        clr_pend_d = clr_pend_q | clear_req;
        capture    = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        case (state_q)
            StIdle: begin
                if (clr_pend_q || clear_req) begin
                    state_d    = StClear;
                    clr_pend_d = 1'b0;
                    op_d       = OpClear;
                    en_d       = '1;
                end else if (br_valid) begin
                    capture = 1'b1;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                state_d = StIssue;
                en_d    = ENTRIES'(1) << sel_idx;
                if (hit_any) begin
                    op_d    = {2'b01, taken_q};
                    mis_d   = ent_insert_bubble[hit_idx];
                    hit_inc = 1'b1;
                end else begin
                    op_d     = {2'b10, taken_q};
                    miss_inc = 1'b1;
                    if (!empty_any) begin
                        victim_d = (victim_q == IDX_W'(ENTRIES - 1)) ? '0 : victim_q + IDX_W'(1);
                    end
                end
            end
            StIssue: begin
                state_d = StIdle;
            end
            StClear: begin
                state_d  = StIdle;
                victim_d = '0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= OpIdle;
            en_q       <= '0;
            mis_q      <= 1'b0;
            victim_q   <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            en_q       <= en_d;
            mis_q      <= mis_d;
            victim_q   <= victim_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else if (capture) begin
            pc_q     <= br_pc[15:5];
            taken_q  <= br_taken;
            target_q <= br_target;
        end
    end

    // Counters update with the registered op so they already reflect it during ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (hit_inc && (hit_q != '1)) begin
                hit_q <= hit_q + CNT_W'(1);
            end
            if (miss_inc && (miss_q != '1)) begin
                miss_q <= miss_q + CNT_W'(1);
            end
        end
    end

    assign ent_op        = op_q;
    assign ent_en        = en_q;
    assign ent_in_pc     = {1'b0, pc_q};
    assign ent_in_target = target_q;
    assign mispredict    = mis_q;
    assign hit_cnt       = hit_q;
    assign miss_cnt      = miss_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: a driver pushes expected entry ops computed by a
// behavioural model, and a negedge monitor pops and compares every op the DUT presents.
module tb_btb_update_ctrl;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          br_valid = 1'b0;
    logic          br_ready;
    logic [15:0]   br_pc = '0;
    logic          br_taken = 1'b0;
    logic [15:0]   br_target = '0;
    logic          clear_req = 1'b0;
    logic [2:0]    ent_op;
    logic [N-1:0]  ent_en;
    logic [11:0]   ent_in_pc;
    logic [15:0]   ent_in_target;
    logic [N-1:0]  ent_update_hit = '0;
    logic [N-1:0]  ent_empty = '0;
    logic [N-1:0]  ent_insert_bubble = '0;
    logic          mispredict;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    btb_update_ctrl #(
        .ENTRIES(N),
        .CNT_W  (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .br_valid         (br_valid),
        .br_ready         (br_ready),
        .br_pc            (br_pc),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .clear_req        (clear_req),
        .ent_op           (ent_op),
        .ent_en           (ent_en),
        .ent_in_pc        (ent_in_pc),
        .ent_in_target    (ent_in_target),
        .ent_update_hit   (ent_update_hit),
        .ent_empty        (ent_empty),
        .ent_insert_bubble(ent_insert_bubble),
        .mispredict       (mispredict),
        .hit_cnt          (hit_cnt),
        .miss_cnt         (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_clr;
        logic [2:0]  op;
        logic [N-1:0] en;
        logic [11:0] pc;
        logic [15:0] tg;
        logic        mis;
        int          hc;
        int          mc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Reference model state: round-robin victim and saturating statistics.
    int   m_victim = 0;
    int   m_hits = 0;
    int   m_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic exp_t model_branch(input logic [15:0] pc, input logic tk,
                                          input logic [15:0] tg, input logic [N-1:0] hit,
                                          input logic [N-1:0] emp, input logic [N-1:0] bub);
        exp_t e;
        int   sel;
        e.is_clr = 1'b0;
        e.pc     = 12'(pc / 32);
        e.tg     = tg;
        sel      = lowest(hit);
        if (sel >= 0) begin
            e.op   = {2'b01, tk};
            e.mis  = bub[sel];
            m_hits = (m_hits < CMAX) ? m_hits + 1 : CMAX;
        end else begin
            e.op   = {2'b10, tk};
            e.mis  = 1'b0;
            sel    = lowest(emp);
            if (sel < 0) begin
                sel      = m_victim;
                m_victim = (m_victim + 1) % N;
            end
            m_miss = (m_miss < CMAX) ? m_miss + 1 : CMAX;
        end
        e.en = N'(1 << sel);
        e.hc = m_hits;
        e.mc = m_miss;
        return e;
    endfunction

    task automatic push_clear();
        exp_t e;
        e.is_clr = 1'b1;
        e.op     = 3'b111;
        e.en     = '1;
        e.pc     = '0;
        e.tg     = '0;
        e.mis    = 1'b0;
        e.hc     = m_hits;
        e.mc     = m_miss;
        m_victim = 0;
        exp_q.push_back(e);
    endtask

    task automatic wait_ready(output bit ok);
        int w = 0;
        @(negedge clk);
        while (!br_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = br_ready;
        chk("ready_wait", 32'(br_ready), 32'd1);
    endtask

    task automatic send(input logic [15:0] pc, input logic tk, input logic [15:0] tg,
                        input logic [N-1:0] hit, input logic [N-1:0] emp,
                        input logic [N-1:0] bub, input bit push);
        bit   ok;
        exp_t e;
        wait_ready(ok);
        if (!ok) return;
        br_valid          = 1'b1;
        br_pc             = pc;
        br_taken          = tk;
        br_target         = tg;
        ent_update_hit    = hit;
        ent_empty         = emp;
        ent_insert_bubble = bub;
        e = model_branch(pc, tk, tg, hit, emp, bub);
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1 br_valid = 1'b0;
    endtask

    task automatic clear_idle();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        clear_req = 1'b1;
        push_clear();
        @(posedge clk);
        #1 clear_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(br_ready), 32'd0);
        chk({tag, "_op"}, 32'(ent_op), 32'd0);
        chk({tag, "_en"}, 32'(ent_en), 32'd0);
        chk({tag, "_in_pc"}, 32'(ent_in_pc), 32'd0);
        chk({tag, "_in_target"}, 32'(ent_in_target), 32'd0);
        chk({tag, "_mispredict"}, 32'(mispredict), 32'd0);
        chk({tag, "_hit_cnt"}, 32'(hit_cnt), 32'd0);
        chk({tag, "_miss_cnt"}, 32'(miss_cnt), 32'd0);
    endtask

    // Monitor: every non-idle op must match the oldest expectation.
    always @(negedge clk) begin
        if (ent_op != 3'b000) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_op actual=%b en=%b required=none at %0t",
                         ent_op, ent_en, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("op", 32'(ent_op), 32'(mon_e.op));
                chk("en", 32'(ent_en), 32'(mon_e.en));
                chk("mispredict", 32'(mispredict), 32'(mon_e.mis));
                chk("hit_cnt", 32'(hit_cnt), 32'(mon_e.hc));
                chk("miss_cnt", 32'(miss_cnt), 32'(mon_e.mc));
                if (!mon_e.is_clr) begin
                    chk("in_pc", 32'(ent_in_pc), 32'(mon_e.pc));
                    chk("in_target", 32'(ent_in_target), 32'(mon_e.tg));
                end
            end
        end else begin
            chk("idle_en", 32'(ent_en), 32'd0);
            chk("idle_mispredict", 32'(mispredict), 32'd0);
        end
    end

    initial begin
        bit           ok;
        int           r;
        logic [N-1:0] h, em, b;

        // Reset values, then ready right after release.
        #2 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_release", 32'(br_ready), 32'd1);

        // Empty BTB miss allocates entry 0.
        send(16'h1234, 1'b1, 16'h2000, 4'b0000, 4'b1111, 4'b0000, 1'b1);
        // Verify hit with mispredict on entry 2.
        send(16'h4321, 1'b0, 16'h0abc, 4'b0100, 4'b0000, 4'b0100, 1'b1);
        // Multiple hits: lowest wins.
        send(16'h8888, 1'b1, 16'h1111, 4'b1010, 4'b0001, 4'b1000, 1'b1);
        // Full BTB: five misses walk the victim pointer round-robin.
        for (int i = 0; i < 5; i++) begin
            send(16'(i * 97 + 3), 1'(i), 16'(i * 13), 4'b0000, 4'b0000, 4'b0000, 1'b1);
        end

        // Clear in the same cycle as a branch: clear wins, branch follows.
        wait_ready(ok);
        br_valid          = 1'b1;
        br_pc             = 16'hbeef;
        br_taken          = 1'b1;
        br_target         = 16'h5555;
        ent_update_hit    = '0;
        ent_empty         = '0;
        ent_insert_bubble = '0;
        clear_req         = 1'b1;
        #1 chk("clr_vs_br_ready", 32'(br_ready), 32'd0);
        push_clear();
        @(posedge clk);
        #1 clear_req = 1'b0;
        @(negedge clk);
        chk("ready_in_clear", 32'(br_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_clear", 32'(br_ready), 32'd1);
        exp_q.push_back(model_branch(16'hbeef, 1'b1, 16'h5555, 4'b0000, 4'b0000, 4'b0000));
        @(posedge clk);
        #1 br_valid = 1'b0;

        // Clear during LOOKUP: branch issues first, then the clear.
        send(16'h0f0f, 1'b0, 16'h7777, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        clear_req = 1'b1;
        push_clear();
        @(posedge clk);
        #1 clear_req = 1'b0;
        send(16'h0ff0, 1'b1, 16'h7070, 4'b0000, 4'b0000, 4'b0000, 1'b1);

        // Reset during ISSUE drops the branch and the pending clear.
        send(16'h3333, 1'b1, 16'h4444, 4'b0010, 4'b0000, 4'b0000, 1'b0);
        clear_req = 1'b1;
        @(posedge clk);
        #1 clear_req = 1'b0;
        chk("issue_before_reset", 32'(ent_op != 3'b000), 32'd1);
        rst_n = 1'b0;
        #1 check_reset_outputs("mid_issue_reset");
        m_victim = 0;
        m_hits   = 0;
        m_miss   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_mid_reset", 32'(br_ready), 32'd1);

        // Saturation of the hit counter.
        for (int i = 0; i < CMAX + 3; i++) begin
            send(16'($urandom), 1'($urandom), 16'($urandom), 4'b0001, 4'b0000, 4'b0000, 1'b1);
        end

        // Randomised traffic with occasional clears.
        for (int k = 0; k < 150; k++) begin
            r  = int'($urandom_range(0, 9));
            h  = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
            em = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
            b  = N'($urandom);
            if (r == 0) clear_idle();
            send(16'($urandom), 1'($urandom), 16'($urandom), h, em, b, 1'b1);
            if (r == 1) begin
                clear_req = 1'b1;
                push_clear();
                @(posedge clk);
                #1 clear_req = 1'b0;
            end
        end

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
